// File: rtl/debug_host_pkg.sv
// debug_host_pkg: command codes, response codes and FSM state type shared by
// the debug host responder and its phase tracker.
`timescale 1ns/1ps
package debug_host_pkg;

  // Command byte codes. 0x00..CMD_READ_IP select a register to read.
  localparam logic [7:0] CMD_READ_IP    = 8'h08;
  localparam logic [7:0] CMD_CONTINUE   = 8'h10;
  localparam logic [7:0] CMD_STATUS     = 8'h11;
  localparam logic [7:0] CMD_WAIT_COUNT = 8'h13;
  localparam logic [7:0] CMD_WAIT_CLEAR = 8'h14;

  // Single-byte reply for anything that cannot be honoured.
  localparam logic [7:0] RSP_ERROR = 8'hEE;

  // Register address of the instruction pointer on the debug port.
  localparam logic [3:0] DEBUG_REG_IP = 4'd8;

  // Responses are serialized from a 24-bit word, LSB first.
  localparam int RSP_WIDTH = 24;

  typedef enum logic [2:0] {
    IDLE,
    REG_SETUP,
    REG_CAPTURE,
    CONT_WAIT,
    SEND
  } state_t;

  // True for the register-read command range r0..r7 plus ip.
  function automatic logic is_read_cmd(input logic [7:0] code);
    return (code <= CMD_READ_IP) && (code[3:0] <= DEBUG_REG_IP);
  endfunction

endpackage

// File: rtl/debug_host_phase_tracker.sv
// debug_host_phase_tracker: mirrors the processor's 4-cycle wait phase.
// A wait_for_continue pulse re-aligns the phase to 1 and marks the processor
// halted; ph == 0 is the cycle in which the processor samples a continue.
`timescale 1ns/1ps
module debug_host_phase_tracker (
  input  logic       clock,
  input  logic       reset,
  input  logic       wait_for_continue,
  input  logic       clear_halted,
  output logic [1:0] ph,
  output logic       halted
);

  // Free-running phase, re-synchronised on every wait pulse; a wait pulse
  // wins over a simultaneous clear so a stray wait is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph     <= 2'd0;
      halted <= 1'b0;
    end else if (wait_for_continue) begin
      ph     <= 2'd1;
      halted <= 1'b1;
    end else begin
      ph <= ph + 2'd1;
      if (clear_halted) begin
        halted <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/debug_host.sv
// debug_host: byte-command responder for the processor's wait/continue and
// debug register read port. Commands arrive on cmd_*, replies leave on rsp_*.
//
// Handshake: a byte moves on a stream in every cycle where valid & ready are
// both high at the rising clock edge; a producer holds valid and data stable
// until that happens. cmd_ready is high only in IDLE, rsp_valid only in SEND.
//
// Optional build macro DEBUG_HOST_WAIT_COUNT_EN adds a saturating 16-bit count
// of halt entries, read with 0x13 (2 bytes, LSB first) and cleared with 0x14.
// WORD_SIZE must not exceed 24 (register replies are 3 bytes).
`timescale 1ns/1ps
module debug_host
  import debug_host_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [7:0]           cmd_data,
  output logic                 cmd_ready,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  input  logic                 rsp_ready,
  input  logic                 wait_for_continue,
  output logic                 wait_continue_execution,
  output logic                 debug_get_param,
  output logic [3:0]           debug_reg_addr,
  input  logic [WORD_SIZE-1:0] debug_data_out
);

  // FSM state is kept as a named signal so checkers can bind to it.
  state_t      state;
  logic [1:0]  ph;
  logic        halted;

  // Bytes still to be sent after rsp_data, and how many of them remain.
  logic [15:0] rsp_rest;
  logic [1:0]  rsp_left;

  // Response load request, decided combinationally from state and inputs.
  logic                 load_en;
  logic [RSP_WIDTH-1:0] load_word;
  logic [1:0]           load_left;

  // The next cycle is the processor's execute quantum.
  logic        lands_next;

  debug_host_phase_tracker u_phase (
    .clock             (clock),
    .reset             (reset),
    .wait_for_continue (wait_for_continue),
    .clear_halted      (wait_continue_execution),
    .ph                (ph),
    .halted            (halted)
  );

  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == SEND);
  assign lands_next = (ph == 2'd3) && !wait_for_continue;

`ifdef DEBUG_HOST_WAIT_COUNT_EN
  logic [15:0] wait_count;
  logic        halted_rise;

  assign halted_rise = wait_for_continue && !halted;

  // Count halt entries, saturating; a clear command takes priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_count <= 16'd0;
    end else if ((state == IDLE) && cmd_valid && (cmd_data == CMD_WAIT_CLEAR)) begin
      wait_count <= 16'd0;
    end else if (halted_rise && (wait_count != 16'hFFFF)) begin
      wait_count <= wait_count + 16'd1;
    end
  end
`endif

  // Decide when a reply is loaded into the serializer and what it holds.
  always_comb begin
    load_en   = 1'b0;
    load_word = '0;
    load_left = 2'd0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (is_read_cmd(cmd_data)) begin
            load_en = 1'b0;
          end else if (cmd_data == CMD_CONTINUE) begin
            if (!halted) begin
              load_en   = 1'b1;
              load_word = {16'd0, RSP_ERROR};
            end
          end else if (cmd_data == CMD_STATUS) begin
            load_en   = 1'b1;
            load_word = {23'd0, halted};
`ifdef DEBUG_HOST_WAIT_COUNT_EN
          end else if (cmd_data == CMD_WAIT_COUNT) begin
            load_en   = 1'b1;
            load_word = {8'd0, wait_count};
            load_left = 2'd1;
          end else if (cmd_data == CMD_WAIT_CLEAR) begin
            load_en   = 1'b1;
            load_word = {16'd0, CMD_WAIT_CLEAR};
`endif
          end else begin
            load_en   = 1'b1;
            load_word = {16'd0, RSP_ERROR};
          end
        end
      end
      REG_CAPTURE: begin
        load_en   = 1'b1;
        load_word = RSP_WIDTH'(debug_data_out);
        load_left = 2'd2;
      end
      CONT_WAIT: begin
        if (wait_continue_execution) begin
          load_en   = 1'b1;
          load_word = {16'd0, CMD_CONTINUE};
        end
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
  end

  // Main FSM: command decode, debug port drive, continue timing, serializer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                   <= IDLE;
      debug_get_param         <= 1'b0;
      debug_reg_addr          <= 4'd0;
      wait_continue_execution <= 1'b0;
      rsp_data                <= 8'd0;
      rsp_rest                <= 16'd0;
      rsp_left                <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (is_read_cmd(cmd_data)) begin
              state           <= REG_SETUP;
              debug_get_param <= 1'b1;
              debug_reg_addr  <= cmd_data[3:0];
            end else if ((cmd_data == CMD_CONTINUE) && halted) begin
              // If the very next cycle is the quantum, pulse there.
              state                   <= CONT_WAIT;
              wait_continue_execution <= lands_next;
            end
          end
        end
        REG_SETUP: begin
          state <= REG_CAPTURE;
        end
        REG_CAPTURE: begin
          debug_get_param <= 1'b0;
        end
        CONT_WAIT: begin
          // The pulse is one cycle wide; the reply is loaded in that cycle.
          if (wait_continue_execution) begin
            wait_continue_execution <= 1'b0;
          end else begin
            wait_continue_execution <= lands_next;
          end
        end
        SEND: begin
          if (rsp_ready) begin
            if (rsp_left == 2'd0) begin
              state <= IDLE;
            end else begin
              rsp_data <= rsp_rest[7:0];
              rsp_rest <= {8'd0, rsp_rest[15:8]};
              rsp_left <= rsp_left - 2'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (load_en) begin
        state    <= SEND;
        rsp_data <= load_word[7:0];
        rsp_rest <= load_word[23:8];
        rsp_left <= load_left;
      end
    end
  end

endmodule

// File: tb/tb_debug_host.sv
// tb_debug_host: randomized self-checking bench for debug_host.
// Cycle c is the interval following the c-th rising clock edge.
`timescale 1ns/1ps
module tb_debug_host;
  import debug_host_pkg::*;

  localparam int WORD_SIZE = 18;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic [7:0]           cmd_data = 8'd0;
  logic                 cmd_ready;
  logic                 rsp_valid;
  logic [7:0]           rsp_data;
  logic                 rsp_ready = 1'b0;
  logic                 wait_for_continue = 1'b0;
  logic                 wait_continue_execution;
  logic                 debug_get_param;
  logic [3:0]           debug_reg_addr;
  logic [WORD_SIZE-1:0] debug_data_out;

  debug_host #(.WORD_SIZE(WORD_SIZE)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_data                (cmd_data),
    .cmd_ready               (cmd_ready),
    .rsp_valid               (rsp_valid),
    .rsp_data                (rsp_data),
    .rsp_ready               (rsp_ready),
    .wait_for_continue       (wait_for_continue),
    .wait_continue_execution (wait_continue_execution),
    .debug_get_param         (debug_get_param),
    .debug_reg_addr          (debug_reg_addr),
    .debug_data_out          (debug_data_out)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Processor register file model: r0..r7 and ip at index 8.
  logic [WORD_SIZE-1:0] regs [0:15];
  assign debug_data_out = regs[debug_reg_addr];

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         hs_q[$];
  int         dgp_q[$];
  logic [3:0] dga_q[$];
  int         pulse_q[$];
  bit         m_halted = 1'b0;
  int         last_w = -1000;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (rsp_valid && rsp_ready) begin
      got_q.push_back(rsp_data);
      hs_q.push_back(cyc);
    end
    if (debug_get_param) begin
      dgp_q.push_back(cyc);
      dga_q.push_back(debug_reg_addr);
    end
    if (wait_continue_execution) pulse_q.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_mon();
    exp_q.delete();
    got_q.delete();
    hs_q.delete();
    dgp_q.delete();
    dga_q.delete();
    pulse_q.delete();
  endtask

  task automatic pulse_wfc();
    wait_for_continue = 1'b1;
    last_w = cyc;
    m_halted = 1'b1;
    tick(1);
    wait_for_continue = 1'b0;
  endtask

  // Offer one command byte; acc returns the cycle it was accepted in.
  task automatic send_cmd(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    acc = -1;
    cmd_valid = 1'b1;
    cmd_data = b;
    while (acc < 0 && n < 200) begin
      @(negedge clock);
      if (cmd_ready) acc = cyc;
      @(posedge clock);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    cmd_data = 8'd0;
    vectors++;
    if (acc < 0) begin
      miscompares++;
      $display("FAIL cmd_accept: code %02h not accepted within 200 cycles", b);
    end
  endtask

  // Consume n response bytes, optionally with random backpressure.
  task automatic drain(input int n, input bit rnd);
    int t;
    t = 0;
    while (got_q.size() < n && t < 300) begin
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(1);
      t++;
    end
    rsp_ready = 1'b0;
    vectors++;
    if (got_q.size() < n) begin
      miscompares++;
      $display("FAIL rsp_timeout: got %0d bytes, required %0d", got_q.size(), n);
    end
  endtask

  // Expected execute quantum: first cycle after acc whose phase is 0.
  function automatic int next_quantum(input int acc);
    int c;
    c = acc + 1;
    while (((c - last_w) % 4) != 0) c++;
    return c;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_data !== 8'd0) begin miscompares++; $display("FAIL reset_rsp_data: got %02h want 00", rsp_data); end
    vectors++; if (debug_get_param !== 1'b0) begin miscompares++; $display("FAIL reset_dgp: got %b want 0", debug_get_param); end
    vectors++; if (debug_reg_addr !== 4'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", debug_reg_addr); end
    vectors++; if (wait_continue_execution !== 1'b0) begin miscompares++; $display("FAIL reset_wce: got %b want 0", wait_continue_execution); end
    @(negedge clock);
    reset = 1'b1;
    m_halted = 1'b0;
    last_w = -1000;
    tick(2);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_status();
    int acc;
    clear_mon();
    send_cmd(CMD_STATUS, acc);
    drain(1, 1'b0);
    vectors++;
    if (got_q.size() < 1 || got_q[0] !== {7'd0, m_halted}) begin
      miscompares++;
      $display("FAIL status: got %02h want %02h", (got_q.size() > 0) ? got_q[0] : 8'hxx, {7'd0, m_halted});
    end
  endtask

  task automatic test_read(input logic [3:0] r, input logic [WORD_SIZE-1:0] val, input bit rnd);
    int acc;
    logic [23:0] w;
    regs[r] = val;
    w = 24'(val);
    clear_mon();
    for (int i = 0; i < 3; i++) exp_q.push_back(w[8*i +: 8]);
    send_cmd({4'd0, r}, acc);
    drain(3, rnd);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL read_r%0d_byte%0d: got %02h want %02h", r, i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    vectors++;
    if (dgp_q.size() != 2 || dgp_q[0] != acc + 1 || dgp_q[1] != acc + 2) begin
      miscompares++;
      $display("FAIL read_dgp_window: %0d cycles high, first %0d, want cycles %0d..%0d",
               dgp_q.size(), (dgp_q.size() > 0) ? dgp_q[0] : -1, acc + 1, acc + 2);
    end
    vectors++;
    if (dga_q.size() != 2 || dga_q[0] !== r || dga_q[1] !== r) begin
      miscompares++;
      $display("FAIL read_addr: got %0d want %0d", (dga_q.size() > 0) ? dga_q[0] : 4'hx, r);
    end
  endtask

  task automatic test_continue(input int npulse, input int gap);
    int acc;
    int exp_c;
    clear_mon();
    pulse_wfc();
    for (int i = 1; i < npulse; i++) begin
      tick(3);
      pulse_wfc();
    end
    tick(gap);
    send_cmd(CMD_CONTINUE, acc);
    exp_c = next_quantum(acc);
    drain(1, 1'b0);
    vectors++;
    if (got_q.size() < 1 || got_q[0] !== CMD_CONTINUE) begin
      miscompares++;
      $display("FAIL continue_rsp: got %02h want 10", (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    vectors++;
    if (pulse_q.size() != 1 || pulse_q[0] != exp_c) begin
      miscompares++;
      $display("FAIL continue_pulse: %0d pulses, first at %0d, want one at %0d (accept %0d, last wait %0d)",
               pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1, exp_c, acc, last_w);
    end
    m_halted = 1'b0;
    test_status();
  endtask

  task automatic test_errors();
    int acc;
    logic [7:0] codes[$];
    clear_mon();
    send_cmd(CMD_CONTINUE, acc);
    drain(1, 1'b0);
    tick(8);
    vectors++;
    if (got_q.size() < 1 || got_q[0] !== RSP_ERROR) begin
      miscompares++;
      $display("FAIL continue_unhalted_rsp: got %02h want ee", (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    vectors++;
    if (pulse_q.size() != 0) begin
      miscompares++;
      $display("FAIL continue_unhalted_pulse: got %0d pulses want 0", pulse_q.size());
    end
    codes.push_back(8'h55);
    codes.push_back(8'h12);
`ifndef DEBUG_HOST_WAIT_COUNT_EN
    codes.push_back(8'h13);
    codes.push_back(8'h14);
`endif
    codes.push_back(8'($urandom_range(9, 15)));
    for (int i = 0; i < 3; i++) codes.push_back(8'($urandom_range(8'h20, 8'hFF)));
    foreach (codes[k]) begin
      clear_mon();
      send_cmd(codes[k], acc);
      drain(1, 1'b1);
      vectors++;
      if (got_q.size() < 1 || got_q[0] !== RSP_ERROR) begin
        miscompares++;
        $display("FAIL unknown_%02h: got %02h want ee", codes[k], (got_q.size() > 0) ? got_q[0] : 8'hxx);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [WORD_SIZE-1:0] val;
    logic [23:0] w;
    val = WORD_SIZE'($urandom());
    regs[2] = val;
    w = 24'(val);
    clear_mon();
    rsp_ready = 1'b0;
    send_cmd(8'h02, acc);
    tick(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_rsp_valid[%0d]: got %b want 1", i, rsp_valid); end
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_cmd_ready[%0d]: got %b want 0", i, cmd_ready); end
      vectors++; if (rsp_data !== w[7:0]) begin miscompares++; $display("FAIL bp_rsp_data[%0d]: got %02h want %02h", i, rsp_data, w[7:0]); end
      @(posedge clock);
      #1;
    end
    drain(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got_q.size() <= i || got_q[i] !== w[8*i +: 8]) begin
        miscompares++;
        $display("FAIL bp_byte%0d: got %02h want %02h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, w[8*i +: 8]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int acc2;
    int last_hs;
    regs[7] = WORD_SIZE'($urandom());
    regs[1] = WORD_SIZE'($urandom());
    clear_mon();
    send_cmd(8'h07, acc);
    drain(3, 1'b0);
    vectors++;
    if (hs_q.size() != 3 || hs_q[0] != acc + 3 || hs_q[1] != acc + 4 || hs_q[2] != acc + 5) begin
      miscompares++;
      $display("FAIL b2b_timing: first byte at %0d want %0d, %0d bytes", (hs_q.size() > 0) ? hs_q[0] : -1, acc + 3, hs_q.size());
    end
    last_hs = (hs_q.size() > 0) ? hs_q[hs_q.size() - 1] : -1;
    clear_mon();
    send_cmd(8'h01, acc2);
    vectors++;
    if (acc2 != last_hs + 1) begin
      miscompares++;
      $display("FAIL b2b_next_accept: accepted at %0d want %0d", acc2, last_hs + 1);
    end
    drain(3, 1'b0);
    vectors++;
    if (got_q.size() != 3 || {got_q[2], got_q[1], got_q[0]} !== 24'(regs[1])) begin
      miscompares++;
      $display("FAIL b2b_second_read: got %0d bytes want %06h", got_q.size(), 24'(regs[1]));
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    pulse_wfc();
    regs[5] = WORD_SIZE'($urandom());
    clear_mon();
    send_cmd(8'h05, acc);
    vectors++; if (debug_get_param !== 1'b1) begin miscompares++; $display("FAIL mid_setup_dgp: got %b want 1", debug_get_param); end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (debug_get_param !== 1'b0) begin miscompares++; $display("FAIL mid_reset_dgp: got %b want 0", debug_get_param); end
    vectors++; if (wait_continue_execution !== 1'b0) begin miscompares++; $display("FAIL mid_reset_wce: got %b want 0", wait_continue_execution); end
    tick(2);
    @(negedge clock);
    reset = 1'b1;
    m_halted = 1'b0;
    last_w = -1000;
    clear_mon();
    rsp_ready = 1'b1;
    tick(12);
    rsp_ready = 1'b0;
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL mid_reset_rsp: got %0d bytes want 0", got_q.size()); end
    vectors++; if (dgp_q.size() != 0) begin miscompares++; $display("FAIL mid_reset_dgp_after: high %0d cycles want 0", dgp_q.size()); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_cmd_ready: got %b want 1", cmd_ready); end
    test_status();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    test_reset();
    test_status();
    test_read(4'd3, 18'h2ABCD, 1'b0);
    test_read(DEBUG_REG_IP, 18'h00105, 1'b0);
    for (int i = 0; i < 6; i++) begin
      test_read(4'($urandom_range(0, 8)), WORD_SIZE'($urandom()), 1'b1);
    end
    pulse_wfc();
    tick(4);
    test_status();
    test_continue(2, 0);
    test_errors();
    for (int i = 0; i < 5; i++) begin
      test_continue($urandom_range(1, 3), $urandom_range(0, 6));
    end
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
